register_file_32x64: RTL and testbench

//  - 32-entry x 64-bit general-purpose register file for the CPU datapath: one write port, two read ports.
//  - Write port decodes the 5-bit destination into 32 one-hot enables, the inverse of the read-side 32:1 selection.
//  - Read ports drive ALU operand A and operand B / store data.
//  - X31 (XZR) is hardwired to zero.
//  - Same-cycle write-to-read forwarding removes the writeback-to-decode hazard.

---
 rtl/register_file_32x64_pkg.sv | 19 +
 rtl/register_file_32x64_decoder_5to32.sv | 25 ++
 rtl/register_file_32x64.sv | 114 +++++++++++
 tb/tb_register_file_32x64.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_32x64_pkg.sv
// ----------------------------------------------------------------------------
// register_file_32x64_pkg
//   Shared definitions for the general-purpose register file. The decode stage
//   and the hazard unit use the same constants.
//   Contents:
//     REG_ADDR_W    width of a register index
//     NUM_REGS      number of architectural registers (including XZR)
//     ZERO_REG_IDX  index of the hardwired-zero register (XZR)
//     reg_addr_t    register index type
// ----------------------------------------------------------------------------
package register_file_32x64_pkg;

   localparam int REG_ADDR_W   = 5;
   localparam int NUM_REGS     = 32;
   localparam int ZERO_REG_IDX = 31;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : register_file_32x64_pkg

// File: rtl/register_file_32x64_decoder_5to32.sv
// ----------------------------------------------------------------------------
// decoder_5to32
//   Converts a 5-bit register index into a 32-bit one-hot select.
//   The output is all-zero when en is low, and otherwise strictly one-hot.
//   Ports:
//     en      in   1   decoder enable
//     addr    in   5   register index
//     onehot  out  32  one-hot select, bit i set when en && addr == i
// ----------------------------------------------------------------------------
module decoder_5to32
   import register_file_32x64_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] addr,
   input  logic                  en,
   output logic [NUM_REGS-1:0]   onehot
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
         assign onehot[gi] = en && (addr == REG_ADDR_W'(gi));
      end
   endgenerate

endmodule : decoder_5to32

// File: rtl/register_file_32x64.sv
// ----------------------------------------------------------------------------
// register_file_32x64
//   32-entry general-purpose register file: one write port and two
//   combinational read ports. Register ZERO_REG (XZR) has no storage and
//   always reads as zero. A write presented in the current cycle is forwarded
//   to any read port that addresses the same register.
//   Parameters:
//     N          data width of every register and data port
//     ZERO_REG   index of the hardwired-zero register
//   Ports:
//     clk        in   1  clock, all state updates on the rising edge
//     reset_n    in   1  asynchronous active-low reset, clears every register
//     wr_en      in   1  write enable
//     wr_addr    in   5  destination register index
//     wr_data    in   N  write data
//     rd_addr_a  in   5  read port A index
//     rd_addr_b  in   5  read port B index
//     rd_data_a  out  N  read port A data (combinational)
//     rd_data_b  out  N  read port B data (combinational)
// ----------------------------------------------------------------------------
module register_file_32x64
   import register_file_32x64_pkg::*;
#(
   parameter int N        = 64,
   parameter int ZERO_REG = ZERO_REG_IDX
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  logic [REG_ADDR_W-1:0] wr_addr,
   input  logic [N-1:0]          wr_data,
   input  logic [REG_ADDR_W-1:0] rd_addr_a,
   input  logic [REG_ADDR_W-1:0] rd_addr_b,
   output logic [N-1:0]          rd_data_a,
   output logic [N-1:0]          rd_data_b
);

   localparam int                    NUM_RD_PORTS = 2;
   localparam logic [REG_ADDR_W-1:0] ZERO_ADDR    = REG_ADDR_W'(ZERO_REG);
   localparam logic [NUM_REGS-1:0]   ZERO_MASK    = NUM_REGS'(1) << ZERO_REG;

   // ------------------------------------------------------------------------
   // Write-side decode. XZR's select bit is cleared here so that the rest of
   // the block sees a select vector that already encodes "write discarded".
   // ------------------------------------------------------------------------
   logic [NUM_REGS-1:0] wr_sel_raw;
   logic [NUM_REGS-1:0] wr_sel;

   decoder_5to32 u_wr_dec (
      .addr   (wr_addr),
      .en     (wr_en),
      .onehot (wr_sel_raw)
   );

   assign wr_sel = wr_sel_raw & ~ZERO_MASK;

   // ------------------------------------------------------------------------
   // Register array. The XZR slot is a constant zero, not a flop.
   // ------------------------------------------------------------------------
   logic [N-1:0] regs [NUM_REGS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         if (gi == ZERO_REG) begin : g_zero
            assign regs[gi] = '0;
         end else begin : g_store
            logic [N-1:0] q_reg;

            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  q_reg <= '0;
               end else if (wr_sel[gi]) begin
                  q_reg <= wr_data;
               end
            end

            assign regs[gi] = q_reg;
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Read ports. The masked write select doubles as the bypass compare:
   // wr_sel[rd_addr] is set exactly when a write to that (non-XZR) register
   // is being presented this cycle. Gating with reset_n keeps the ports at
   // zero while the array is held in reset.
   // ------------------------------------------------------------------------
   logic [REG_ADDR_W-1:0] rd_addr [NUM_RD_PORTS];
   logic [N-1:0]          rd_data [NUM_RD_PORTS];

   assign rd_addr[0] = rd_addr_a;
   assign rd_addr[1] = rd_addr_b;

   generate
      for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
         logic bypass;

         assign bypass = reset_n && wr_sel[rd_addr[gi]];

         always_comb begin
            rd_data[gi] = '0;
            if (rd_addr[gi] != ZERO_ADDR) begin
               rd_data[gi] = bypass ? wr_data : regs[rd_addr[gi]];
            end
         end
      end
   endgenerate

   assign rd_data_a = rd_data[0];
   assign rd_data_b = rd_data[1];

endmodule : register_file_32x64

// File: tb/tb_register_file_32x64.sv
// ----------------------------------------------------------------------------
// tb_register_file_32x64
//   Scoreboard bench for register_file_32x64. The stimulus process sets up a
//   read/write situation, derives the expected read data from a simple array
//   model of the architectural registers, pushes it to a queue and strobes the
//   monitor, which pops and compares against the DUT outputs.
// ----------------------------------------------------------------------------
module tb_register_file_32x64;

   localparam int N = 64;

   logic         clk;
   logic         reset_n;
   logic         wr_en;
   logic [4:0]   wr_addr;
   logic [N-1:0] wr_data;
   logic [4:0]   rd_addr_a;
   logic [4:0]   rd_addr_b;
   logic [N-1:0] rd_data_a;
   logic [N-1:0] rd_data_b;

   register_file_32x64 #(.N(N), .ZERO_REG(31)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural state of X0..X31 as seen by software.
   logic [N-1:0] model [32];

   typedef struct {
      string        name;
      logic [N-1:0] exp_a;
      logic [N-1:0] exp_b;
   } exp_t;

   exp_t exp_q[$];
   event chk_ev;
   int   total = 0;
   int   bad   = 0;

   // Value a read of register a must produce right now.
   function automatic logic [N-1:0] ref_read(input int a);
      if (a == 31)                          return '0;
      if (!reset_n)                         return '0;
      if (wr_en && (int'(wr_addr) == a))    return wr_data;
      return model[a];
   endfunction

   task automatic check(input string name);
      exp_t e;
      #2;
      e.name  = name;
      e.exp_a = ref_read(int'(rd_addr_a));
      e.exp_b = ref_read(int'(rd_addr_b));
      exp_q.push_back(e);
      -> chk_ev;
      #1;
   endtask

   // Advance one clock; the model commits the write seen at the edge.
   task automatic tick();
      @(posedge clk);
      if (reset_n && wr_en && wr_addr != 5'd31) model[wr_addr] = wr_data;
      #1;
   endtask

   task automatic set_io(input logic we, input int wa, input logic [N-1:0] wd,
                         input int ra, input int rb);
      wr_en     = we;
      wr_addr   = 5'(wa);
      wr_data   = wd;
      rd_addr_a = 5'(ra);
      rd_addr_b = 5'(rb);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = '0;
   endtask

   // Monitor: compares every pending expectation when strobed.
   initial begin
      forever begin
         @(chk_ev);
         while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (rd_data_a !== e.exp_a) begin
               bad++;
               $display("FAIL %s port A: got %h expected %h", e.name, rd_data_a, e.exp_a);
            end
            total++;
            if (rd_data_b !== e.exp_b) begin
               bad++;
               $display("FAIL %s port B: got %h expected %h", e.name, rd_data_b, e.exp_b);
            end
            $display("check %s: ra=%0d a=%h rb=%0d b=%h", e.name, rd_addr_a, rd_data_a,
                     rd_addr_b, rd_data_b);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] d;
      int           ra, rb;

      clear_model();
      reset_n = 1'b0;
      set_io(1'b0, 0, '0, 0, 0);

      // Reset held for two cycles; writes presented meanwhile are ignored.
      #1;
      set_io(1'b1, 4, 64'hAAAA_5555_AAAA_5555, 4, 4);
      check("in_reset_write_ignored");
      tick();
      tick();
      reset_n = 1'b1;
      set_io(1'b0, 0, '0, 0, 0);
      check("after_release_no_write");

      // Every address reads zero after reset.
      for (int i = 0; i < 32; i++) begin
         set_io(1'b0, 0, '0, i, 31 - i);
         check($sformatf("reset_read_%0d", i));
      end

      // X5 write then read on both ports.
      set_io(1'b1, 5, 64'hDEAD_BEEF_0000_0001, 0, 1);
      tick();
      set_io(1'b0, 0, '0, 5, 5);
      check("x5_both_ports");

      // XZR write is discarded, including during the write itself.
      set_io(1'b1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31);
      check("xzr_during_write");
      tick();
      set_io(1'b0, 0, '0, 31, 5);
      check("xzr_after_write");

      // Forwarding: X7 = 0x55, then same-cycle write of 0x1234.
      set_io(1'b1, 7, 64'h55, 0, 0);
      tick();
      set_io(1'b0, 0, '0, 7, 0);
      check("x7_old_value");
      set_io(1'b1, 7, 64'h1234, 7, 7);
      check("x7_bypass");
      tick();
      set_io(1'b0, 0, '0, 7, 5);
      check("x7_after_edge");

      // wr_en=0: no update and no forwarding.
      set_io(1'b1, 3, 64'h77, 0, 0);
      tick();
      set_io(1'b0, 3, 64'hAB, 3, 3);
      check("x3_no_bypass");
      tick();
      check("x3_unchanged");

      // Randomized traffic, biased toward address collisions.
      for (int n = 0; n < 300; n++) begin
         d  = {$urandom, $urandom};
         ra = $urandom_range(0, 31);
         rb = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 31);
         set_io(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? ra : $urandom_range(0, 31),
                d, ra, rb);
         check($sformatf("rand_%0d", n));
         tick();
      end

      // Fill X0..X30 with their index and read a few back.
      for (int i = 0; i < 31; i++) begin
         set_io(1'b1, i, 64'(i), 0, 0);
         tick();
      end
      for (int i = 0; i < 32; i += 6) begin
         set_io(1'b0, 0, '0, i, 30 - (i % 31));
         check($sformatf("fill_read_%0d", i));
      end

      // Reset asserted between edges while a write is pending.
      set_io(1'b1, 10, 64'hCAFE_F00D_CAFE_F00D, 10, 20);
      check("pending_write_bypass");
      reset_n = 1'b0;
      clear_model();
      check("async_reset_reads_zero");
      set_io(1'b1, 10, 64'hCAFE_F00D_CAFE_F00D, 1, 30);
      check("async_reset_other_regs");
      tick();
      reset_n = 1'b1;
      set_io(1'b0, 0, '0, 10, 0);
      check("pending_write_lost");
      for (int i = 0; i < 32; i += 3) begin
         set_io(1'b0, 0, '0, i, 31 - i);
         check($sformatf("post_reset_read_%0d", i));
      end

      // First write after release lands on the first edge.
      set_io(1'b1, 12, 64'h0123_4567_89AB_CDEF, 0, 0);
      tick();
      set_io(1'b0, 0, '0, 12, 12);
      check("first_write_after_reset");

      #5;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_register_file_32x64
